debug_clock_display: RTL and testbench
======================================

// Module: debug_clock_display
// PURPOSE
//   Board-test support block that paces the multicycle processor and formats its state for display.
//   Produces a one-cycle processor clock-enable (oTick) in pause / free-run / single-step / fast modes.
//   Converts a selected register to packed BCD with an iterative shift-add-3 engine.
//   Sits between the board I/O (50 MHz clock, switches, keys) and the processor / 7-segment decoders.
// PARAMETERS
//   DIV_BITS      25  free-run tick period = 2**DIV_BITS Clock cycles
//   DATA_W        16  width of one processor register
//   NUM_REGS      8   registers packed in iRegs; SEL_W = $clog2(NUM_REGS)
//   BCD_DIGITS    5   output decimal digits; must satisfy 10**BCD_DIGITS > 2**DATA_W-1
//   DEBOUNCE_BITS 16  iStep must be stable for 2**DEBOUNCE_BITS cycles to be accepted
// PORTS
//   Clock      in   1                 system clock; the only clock
//   Resetn     in   1                 reset, synchronous, active-low
//   iMode      in   2                 00 pause, 01 free-run, 10 single-step, 11 fast (tick every cycle)
//   iStep      in   1                 raw step pushbutton, active-high, asynchronous and bouncy
//   iSel       in   SEL_W             index of the register to convert
//   iRegs      in   DATA_W*NUM_REGS   register file snapshot; reg k = iRegs[k*DATA_W +: DATA_W]
//   oTick      out  1                 one-cycle processor clock-enable pulse
//   oTickCount out  16                number of ticks issued since reset, wraps
//   oBcd       out  4*BCD_DIGITS      last completed conversion, digit 0 in [3:0]
//   oBcdValid  out  1                 oBcd reflects the current request; no conversion in flight or pending
// BEHAVIOUR
//   Reset (Resetn=0 at posedge): all outputs 0, except oBcdValid=0.
//     Divider, debouncer, FSM and pending flag are cleared.
//     A conversion request is raised on the first cycle after reset.
//   Input sync: iStep passes through 2 flops. Debounce counter restarts on every change of the synced level.
//     The debounced level updates only when the counter saturates at 2**DEBOUNCE_BITS-1.
//   Divider: DIV_BITS counter, cleared on any iMode change.
//     01: oTick=1 in the cycle the counter wraps (all ones -> 0).
//     00/10: the counter holds at 0.
//     11: oTick=1 every cycle.
//   Step: a rising edge of the debounced level in mode 10 gives exactly one oTick, 1 cycle after the edge.
//     Edges in any other mode are discarded, not queued.
//   oTickCount increments on each oTick and wraps 16'hFFFF -> 0.
//   Conversion request: oTick, a change of iSel, or reset release.
//   FSM IDLE -> LOAD -> SHIFT -> DONE -> IDLE (or LOAD if pending).
//     LOAD (1 cycle): snapshot = reg[iSel]; iSel >= NUM_REGS snapshots 0.
//     SHIFT (DATA_W cycles): per cycle, add 3 to every BCD digit >= 5, then shift {bcd,snap} left 1.
//     DONE (1 cycle): oBcd <= bcd.
//   Latency: request seen in IDLE -> oBcd updated DATA_W+2 cycles later.
//     oBcdValid rises in that same cycle if nothing is pending.
//   A request while in LOAD/SHIFT/DONE sets a single pending flag; multiple requests coalesce.
//     Pending makes DONE go directly to LOAD (new snapshot) and keeps oBcdValid=0.
//   oBcdValid=0 from the cycle after any request until its conversion completes.
//     oBcd keeps its old value meanwhile.
//   Simultaneous request and DONE: counts as pending and restarts.
//   Simultaneous oTick and iSel change: a single request.
//   Reset mid-conversion: aborts immediately with oBcd=0; a fresh conversion follows.
// TESTING
//   1 DIV_BITS=4, iMode=01 for 100 cycles -> oTick every 16 cycles; oTickCount = 6 after the 6th pulse.
//   2 DEBOUNCE_BITS=3, iMode=10; iStep bounces 3x in under 8 cycles, then holds high 20 cycles
//     -> exactly 1 oTick and oTickCount=1. A press in mode 00 -> no tick.
//   3 reg3=16'hFFFF, iSel=3, idle -> oBcd=20'h65535, valid DATA_W+2=18 cycles after the request.
//     reg0=0 -> 20'h00000.
//   4 iSel 3->5 during SHIFT, reg5=16'd1234 -> first result completes with valid still 0, restarts.
//     oBcd=20'h01234 and oBcdValid=1 after the second conversion.
//   5 Resetn=0 for 1 cycle mid-SHIFT -> next cycle all outputs 0.
//     A new conversion of reg[iSel] completes 18 cycles after release.
//   6 iMode=11 for 70000 cycles -> oTick every cycle; oTickCount wraps through 0.
//     Divider cleared on switching to 01.

Source files
------------

// File: rtl/debug_clock_display.sv
// Board-test pacing for the multicycle core: tick generator, step debouncer
// and an iterative binary-to-BCD converter for the selected register.
module debug_clock_display #(
    parameter int DIV_BITS      = 25,
    parameter int DATA_W        = 16,
    parameter int NUM_REGS      = 8,
    parameter int SEL_W         = $clog2(NUM_REGS),
    parameter int BCD_DIGITS    = 5,
    parameter int DEBOUNCE_BITS = 16
) (
    input  logic                       Clock,
    input  logic                       Resetn,
    input  logic [1:0]                 iMode,
    input  logic                       iStep,
    input  logic [SEL_W-1:0]           iSel,
    input  logic [DATA_W*NUM_REGS-1:0] iRegs,
    output logic                       oTick,
    output logic [15:0]                oTickCount,
    output logic [4*BCD_DIGITS-1:0]    oBcd,
    output logic                       oBcdValid
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int BCD_W = 4 * BCD_DIGITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    logic                     step_s1, step_s2, step_s3;
    logic [DEBOUNCE_BITS-1:0] db_cnt;
    logic                     step_db, step_db_q;
    logic                     step_rise;

    logic [1:0]          mode_q;
    logic                mode_chg;
    logic [DIV_BITS-1:0] div;
    logic                tick_d;

    logic [SEL_W-1:0] sel_q;
    logic             init_q;
    logic             req;
    logic             pending_q;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   sh_cnt;
    logic [DATA_W-1:0]  snap;
    logic [DATA_W-1:0]  sel_word;
    logic [BCD_W-1:0]   bcd;
    logic [BCD_W-1:0]   bcd_adj;

    // Step button: two-flop sync, then accept a level only after it sat still
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            step_s1   <= 1'b0;
            step_s2   <= 1'b0;
            step_s3   <= 1'b0;
            db_cnt    <= '0;
            step_db   <= 1'b0;
            step_db_q <= 1'b0;
        end else begin
            step_s1   <= iStep;
            step_s2   <= step_s1;
            step_s3   <= step_s2;
            step_db_q <= step_db;
            if (step_s2 != step_s3) begin
                db_cnt <= '0;
            end else if (db_cnt != '1) begin
                db_cnt <= db_cnt + 1'b1;
            end
            if (db_cnt == '1) begin
                step_db <= step_s3;
            end
        end
    end

    assign step_rise = step_db & ~step_db_q;
    assign mode_chg  = (iMode != mode_q);

    always_comb begin
        tick_d = 1'b0;
        unique case (iMode)
            2'b01:   tick_d = !mode_chg && (div == '1);
            2'b10:   tick_d = step_rise;
            2'b11:   tick_d = 1'b1;
            default: tick_d = 1'b0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            mode_q     <= 2'b00;
            div        <= '0;
            oTick      <= 1'b0;
            oTickCount <= '0;
        end else begin
            mode_q     <= iMode;
            oTick      <= tick_d;
            oTickCount <= oTickCount + {15'b0, oTick};
            if (mode_chg || iMode != 2'b01) begin
                div <= '0;
            end else begin
                div <= div + 1'b1;
            end
        end
    end

    // Ticks, selector changes and reset release all coalesce into one request
    assign req = oTick | (iSel != sel_q) | init_q;

    always_comb begin
        sel_word = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (iSel == SEL_W'(k)) begin
                sel_word = iRegs[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (req) state_d = S_LOAD;
            S_LOAD:  state_d = S_SHIFT;
            S_SHIFT: if (sh_cnt == CNT_W'(DATA_W - 1)) state_d = S_DONE;
            S_DONE:  state_d = (pending_q || req) ? S_LOAD : S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q   <= S_IDLE;
            sel_q     <= '0;
            init_q    <= 1'b1;
            pending_q <= 1'b0;
            sh_cnt    <= '0;
            snap      <= '0;
            bcd       <= '0;
            oBcd      <= '0;
            oBcdValid <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= iSel;
            init_q  <= 1'b0;
            if (state_q == S_DONE) begin
                pending_q <= 1'b0;
            end else if (state_q != S_IDLE && req) begin
                pending_q <= 1'b1;
            end
            if (state_q == S_DONE) begin
                oBcd      <= bcd;
                oBcdValid <= !(pending_q || req);
            end else if (req) begin
                oBcdValid <= 1'b0;
            end
            if (state_q == S_LOAD) begin
                snap   <= sel_word;
                bcd    <= '0;
                sh_cnt <= '0;
            end else if (state_q == S_SHIFT) begin
                {bcd, snap} <= {bcd_adj, snap} << 1;
                sh_cnt      <= sh_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_debug_clock_display.sv
// Randomized bench for debug_clock_display against a behavioural model:
// arithmetic BCD, tick schedule from mode age, press-level step counting.
module tb_debug_clock_display;

    localparam int DIV_BITS  = 4;
    localparam int DATA_W    = 16;
    localparam int NUM_REGS  = 8;
    localparam int SEL_W     = 3;
    localparam int DIGITS    = 5;
    localparam int DEB_BITS  = 3;
    localparam int PERIOD    = 1 << DIV_BITS;
    localparam int CONV_LAT  = DATA_W + 2;

    logic                       Clock = 1'b0;
    logic                       Resetn;
    logic [1:0]                 iMode;
    logic                       iStep;
    logic [SEL_W-1:0]           iSel;
    logic [DATA_W*NUM_REGS-1:0] iRegs;
    logic                       oTick;
    logic [15:0]                oTickCount;
    logic [4*DIGITS-1:0]        oBcd;
    logic                       oBcdValid;

    debug_clock_display #(
        .DIV_BITS      (DIV_BITS),
        .DATA_W        (DATA_W),
        .NUM_REGS      (NUM_REGS),
        .SEL_W         (SEL_W),
        .BCD_DIGITS    (DIGITS),
        .DEBOUNCE_BITS (DEB_BITS)
    ) dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .iMode      (iMode),
        .iStep      (iStep),
        .iSel       (iSel),
        .iRegs      (iRegs),
        .oTick      (oTick),
        .oTickCount (oTickCount),
        .oBcd       (oBcd),
        .oBcdValid  (oBcdValid)
    );

    always #5 Clock = ~Clock;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] regs [NUM_REGS];
    logic [19:0] cur_bcd;
    logic [15:0] exp_cnt;
    logic [1:0]  last_m;
    int          age;
    int          seen;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    function automatic logic [19:0] to_bcd(input logic [15:0] v);
        logic [19:0] r;
        int x;
        r = '0;
        x = int'(v);
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] rand_word();
        case ($urandom_range(0, 3))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic pack_regs();
        for (int k = 0; k < NUM_REGS; k++) iRegs[k*16 +: 16] = regs[k];
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (oBcdValid) begin
                n = i;
                return;
            end
        end
        check("valid_timeout", {31'b0, oBcdValid}, 1);
    endtask

    // Request lands on the first edge; result is due CONV_LAT edges later
    task automatic convert(input logic [SEL_W-1:0] sel, input string tag);
        int n;
        iSel = sel;
        step();
        check({tag, "_vlow"}, {31'b0, oBcdValid}, 0);
        check({tag, "_hold"}, {12'b0, oBcd}, {12'b0, cur_bcd});
        wait_valid(n);
        check({tag, "_lat"}, n, CONV_LAT);
        cur_bcd = to_bcd(regs[sel]);
        check({tag, "_bcd"}, {12'b0, oBcd}, {12'b0, cur_bcd});
    endtask

    task automatic tick_cycle(input logic [1:0] m);
        logic exp_t;
        if (m == last_m) age++;
        else age = 0;
        last_m = m;
        exp_t = (m == 2'b11) || (m == 2'b01 && age > 0 && age % PERIOD == 0);
        iMode = m;
        step();
        check("tick", {31'b0, oTick}, {31'b0, exp_t});
        check("tick_count", {16'b0, oTickCount}, {16'b0, exp_cnt});
        exp_cnt = exp_cnt + {15'b0, exp_t};
    endtask

    task automatic hold(input logic v, input int cyc);
        iStep = v;
        repeat (cyc) begin
            step();
            if (oTick) seen++;
        end
    endtask

    task automatic press(input int bounces, input bit fast);
        for (int b = 0; b < bounces; b++) begin
            hold(1'b1, fast ? 1 : $urandom_range(1, 6));
            hold(1'b0, fast ? 1 : $urandom_range(1, 6));
        end
        hold(1'b1, 20);
        hold(1'b0, 20);
    endtask

    task automatic press_check(input string tag, input int exp_ticks,
                               input int bounces, input bit fast);
        seen = 0;
        press(bounces, fast);
        exp_cnt = exp_cnt + 16'(exp_ticks);
        check({tag, "_ticks"}, seen, exp_ticks);
        check({tag, "_count"}, {16'b0, oTickCount}, {16'b0, exp_cnt});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [SEL_W-1:0] s;
        int n;
        Resetn = 1'b0;
        iMode  = 2'b00;
        iStep  = 1'b0;
        iSel   = '0;
        for (int k = 0; k < NUM_REGS; k++) regs[k] = rand_word();
        pack_regs();
        repeat (3) step();
        check("rst_tick", {31'b0, oTick}, 0);
        check("rst_count", {16'b0, oTickCount}, 0);
        check("rst_bcd", {12'b0, oBcd}, 0);
        check("rst_valid", {31'b0, oBcdValid}, 0);

        Resetn  = 1'b1;
        cur_bcd = '0;
        exp_cnt = '0;
        last_m  = 2'b00;
        age     = 0;
        step();
        check("init_vlow", {31'b0, oBcdValid}, 0);
        wait_valid(n);
        check("init_lat", n, CONV_LAT);
        cur_bcd = to_bcd(regs[0]);
        check("init_bcd", {12'b0, oBcd}, {12'b0, cur_bcd});

        regs[3] = 16'hFFFF;
        pack_regs();
        convert(3'd3, "max");
        check("max_lit", {12'b0, oBcd}, 32'h65535);
        regs[0] = 16'h0000;
        pack_regs();
        convert(3'd0, "zero");

        // Selector moves mid-conversion: stale result lands, then a restart
        regs[3] = 16'hFFFF;
        regs[5] = 16'd1234;
        pack_regs();
        iSel = 3'd3;
        step();
        repeat (4) step();
        iSel = 3'd5;
        repeat (14) step();
        check("coal_first", {12'b0, oBcd}, {12'b0, to_bcd(16'hFFFF)});
        check("coal_vlow", {31'b0, oBcdValid}, 0);
        wait_valid(n);
        check("coal_lat", n, CONV_LAT);
        cur_bcd = to_bcd(16'd1234);
        check("coal_bcd", {12'b0, oBcd}, 32'h01234);

        do s = SEL_W'($urandom_range(0, NUM_REGS - 1)); while (s == iSel);
        iSel = s;
        step();
        repeat (5) step();
        Resetn = 1'b0;
        step();
        check("mid_rst_tick", {31'b0, oTick}, 0);
        check("mid_rst_count", {16'b0, oTickCount}, 0);
        check("mid_rst_bcd", {12'b0, oBcd}, 0);
        check("mid_rst_valid", {31'b0, oBcdValid}, 0);
        Resetn  = 1'b1;
        cur_bcd = '0;
        exp_cnt = '0;
        step();
        check("post_rst_vlow", {31'b0, oBcdValid}, 0);
        wait_valid(n);
        check("post_rst_lat", n, CONV_LAT);
        cur_bcd = to_bcd(regs[s]);
        check("post_rst_bcd", {12'b0, oBcd}, {12'b0, cur_bcd});

        for (int t = 0; t < 8; t++) begin
            for (int k = 0; k < NUM_REGS; k++) regs[k] = rand_word();
            pack_regs();
            do s = SEL_W'($urandom_range(0, NUM_REGS - 1)); while (s == iSel);
            convert(s, "rand");
        end

        for (int i = 0; i < 100; i++) tick_cycle(2'b01);
        check("six_ticks", {16'b0, oTickCount}, 6);
        for (int i = 0; i < 3; i++) tick_cycle(2'b11);
        for (int i = 0; i < 40; i++) tick_cycle(2'b01);

        iMode = 2'b10;
        hold(1'b0, 5);
        press_check("step_canon", 1, 3, 1'b1);
        for (int t = 0; t < 3; t++) begin
            press_check("step_rand", 1, $urandom_range(0, 4), 1'b0);
        end
        iMode = 2'b00;
        hold(1'b0, 3);
        press_check("pause_press", 0, $urandom_range(0, 4), 1'b0);
        seen = 0;
        hold(1'b1, 20);
        iMode = 2'b10;
        hold(1'b1, 10);
        hold(1'b0, 20);
        check("no_queue_ticks", seen, 0);
        check("no_queue_count", {16'b0, oTickCount}, {16'b0, exp_cnt});

        last_m = iMode;
        age    = 0;
        for (int i = 0; i < 70000; i++) tick_cycle(2'b11);
        for (int i = 0; i < 40; i++) tick_cycle(2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
